// File: rtl/password_entry_ctrl.sv
// Keypad password entry controller.
// Collects four digit keys into a shifting display buffer and checks the
// code on ENTER. A match opens the lock for a timed hold. Repeated mismatches
// lead to a timed lockout with an alarm. All outputs come straight from registers.
module password_entry_ctrl #(
  parameter logic [15:0] PASSWORD    = 16'h1234,
  parameter int          MAX_FAIL    = 3,
  parameter int          HOLD_CYCLES = 50000000,
  parameter int          LOCK_CYCLES = 250000000,
  parameter logic [3:0]  BLANK       = 4'hF,
  parameter logic [3:0]  ERR         = 4'hE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       unlock,
  output logic       alarm,
  output logic [1:0] fail_cnt,
  output logic       busy
);

  // One timer serves both OPEN and LOCKED, so it is sized for the longer of the two.
  localparam int MAX_CYCLES = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    FAIL_LAST = 2'(MAX_FAIL - 1);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    CHECK  = 2'd1,
    OPEN   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t          state_reg;
  // Index 3 is the oldest digit (leftmost), index 0 the newest.
  logic [3:0][3:0] digits_reg;
  logic [2:0]      count_reg;
  logic [TW-1:0]   timer_reg;
  logic [1:0]      fail_reg;
  logic            unlock_reg;
  logic            alarm_reg;
  logic            busy_reg;

  assign digit0   = digits_reg[0];
  assign digit1   = digits_reg[1];
  assign digit2   = digits_reg[2];
  assign digit3   = digits_reg[3];
  assign unlock   = unlock_reg;
  assign alarm    = alarm_reg;
  assign fail_cnt = fail_reg;
  assign busy     = busy_reg;

  // Entry/check/open/lockout state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ENTRY;
      digits_reg <= {4{BLANK}};
      count_reg  <= 3'd0;
      timer_reg  <= '0;
      fail_reg   <= 2'd0;
      unlock_reg <= 1'b0;
      alarm_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ENTRY: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              // A full buffer ignores further digits instead of scrolling.
              if (count_reg != 3'd4) begin
                digits_reg <= {digits_reg[2:0], key_code};
                count_reg  <= count_reg + 3'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              digits_reg <= {4{BLANK}};
              count_reg  <= 3'd0;
            end else if (key_code == KEY_ENTER && count_reg == 3'd4) begin
              state_reg <= CHECK;
              busy_reg  <= 1'b1;
            end
          end
        end

        CHECK: begin
          if (digits_reg == PASSWORD) begin
            state_reg  <= OPEN;
            unlock_reg <= 1'b1;
            fail_reg   <= 2'd0;
            timer_reg  <= '0;
          end else if (fail_reg == FAIL_LAST) begin
            state_reg  <= LOCKED;
            alarm_reg  <= 1'b1;
            fail_reg   <= 2'd0;
            timer_reg  <= '0;
            digits_reg <= {4{ERR}};
            count_reg  <= 3'd0;
          end else begin
            state_reg  <= ENTRY;
            busy_reg   <= 1'b0;
            fail_reg   <= fail_reg + 2'd1;
            digits_reg <= {4{BLANK}};
            count_reg  <= 3'd0;
          end
        end

        OPEN: begin
          // Clear relocks early; otherwise stay open until the hold time runs out.
          if ((key_valid && key_code == KEY_CLEAR) || timer_reg == HOLD_LAST) begin
            state_reg  <= ENTRY;
            unlock_reg <= 1'b0;
            busy_reg   <= 1'b0;
            digits_reg <= {4{BLANK}};
            count_reg  <= 3'd0;
            timer_reg  <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        LOCKED: begin
          // No key can shorten the lockout.
          if (timer_reg == LOCK_LAST) begin
            state_reg  <= ENTRY;
            alarm_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            digits_reg <= {4{BLANK}};
            count_reg  <= 3'd0;
            timer_reg  <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        default: state_reg <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_password_entry_ctrl.sv
// Testbench for password_entry_ctrl: directed scenarios followed by random
// key traffic, each cycle compared against a behavioural model that tracks
// the entered digits as a queue and the open/lockout periods as remaining time.
module tb_password_entry_ctrl;

  localparam logic [15:0] PW   = 16'h1234;
  localparam int          MAXF = 3;
  localparam int          HOLD = 8;
  localparam int          LOCK = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       unlock, alarm, busy;
  logic [1:0] fail_cnt;

  int checks   = 0;
  int failures = 0;

  password_entry_ctrl #(
    .PASSWORD   (PW),
    .MAX_FAIL   (MAXF),
    .HOLD_CYCLES(HOLD),
    .LOCK_CYCLES(LOCK),
    .BLANK      (4'hF),
    .ERR        (4'hE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .unlock   (unlock),
    .alarm    (alarm),
    .fail_cnt (fail_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode, digits typed so far (oldest first), failures, time left.
  localparam int M_ENTRY = 0;
  localparam int M_CHECK = 1;
  localparam int M_OPEN  = 2;
  localparam int M_LOCK  = 3;

  int m_mode;
  int m_buf[$];
  int m_fail;
  int m_left;

  function automatic int pw_digit(input int k);
    return int'((PW >> (4 * (3 - k))) & 16'hF);
  endfunction

  task automatic model_reset();
    m_mode = M_ENTRY;
    m_buf.delete();
    m_fail = 0;
    m_left = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    bit ok;
    case (m_mode)
      M_ENTRY: begin
        if (v) begin
          if (int'(c) <= 9) begin
            if (m_buf.size() < 4) m_buf.push_back(int'(c));
          end else if (c == 4'hA) begin
            m_buf.delete();
          end else if (c == 4'hB && m_buf.size() == 4) begin
            m_mode = M_CHECK;
          end
        end
      end
      M_CHECK: begin
        ok = 1'b1;
        for (int k = 0; k < 4; k++)
          if (m_buf[k] != pw_digit(k)) ok = 1'b0;
        if (ok) begin
          m_mode = M_OPEN;
          m_left = HOLD;
          m_fail = 0;
        end else if (m_fail + 1 < MAXF) begin
          m_fail++;
          m_buf.delete();
          m_mode = M_ENTRY;
        end else begin
          m_mode = M_LOCK;
          m_left = LOCK;
          m_fail = 0;
          m_buf.delete();
        end
      end
      M_OPEN: begin
        m_left--;
        if ((v && c == 4'hA) || m_left == 0) begin
          m_mode = M_ENTRY;
          m_buf.delete();
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = M_ENTRY;
      end
    endcase
  endtask

  function automatic int exp_digit(input int i);
    if (m_mode == M_LOCK) return 14;
    if (i < m_buf.size()) return m_buf[m_buf.size() - 1 - i];
    return 15;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".digit0"}, int'(digit0), exp_digit(0));
    check({ctx, ".digit1"}, int'(digit1), exp_digit(1));
    check({ctx, ".digit2"}, int'(digit2), exp_digit(2));
    check({ctx, ".digit3"}, int'(digit3), exp_digit(3));
    check({ctx, ".unlock"}, int'(unlock), (m_mode == M_OPEN) ? 1 : 0);
    check({ctx, ".alarm"}, int'(alarm), (m_mode == M_LOCK) ? 1 : 0);
    check({ctx, ".fail_cnt"}, int'(fail_cnt), m_fail);
    check({ctx, ".busy"}, int'(busy), (m_mode != M_ENTRY) ? 1 : 0);
  endtask

  // One clock cycle with the given key input, then compare all outputs.
  task automatic tick(input logic v, input logic [3:0] c, input string ctx);
    @(negedge clk);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    check_all(ctx);
    $display("cyc t=%0t kv=%0b key=%0h digits=%0h%0h%0h%0h unlock=%0b alarm=%0b fail=%0d busy=%0b",
             $time, v, c, digit3, digit2, digit1, digit0, unlock, alarm, fail_cnt, busy);
  endtask

  task automatic press(input logic [3:0] c, input string ctx);
    tick(1'b1, c, ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, ctx);
  endtask

  task automatic enter_code(input logic [15:0] code, input string ctx);
    logic [15:0] w;
    w = code;
    for (int k = 0; k < 4; k++) press(w[15 - 4*k -: 4], ctx);
    press(4'hB, ctx);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic async_reset(input string ctx);
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({ctx, ".immediate"});
    @(posedge clk);
    #1;
    check_all({ctx, ".held"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int r;
    logic [15:0] code;
    model_reset();
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2, "post_reset");

    // Correct code: latency, hold length, return to blank
    enter_code(16'h1234, "open");
    idle(HOLD + 4, "open_hold");

    // Fifth digit ignored, clear, short code ENTER ignored
    for (int k = 1; k <= 5; k++) press(4'(k), "overflow");
    press(4'hA, "clear1");
    press(4'h1, "short");
    press(4'h2, "short");
    press(4'hB, "short_enter");
    idle(2, "short_idle");
    press(4'hA, "clear2");

    // Three wrong codes: fail counts then lockout with keys ignored
    enter_code(16'h9999, "wrong1");
    idle(2, "wrong1_idle");
    enter_code(16'h9999, "wrong2");
    idle(2, "wrong2_idle");
    enter_code(16'h9999, "wrong3");
    idle(2, "lock");
    press(4'h1, "lock_key");
    press(4'hA, "lock_clear");
    press(4'hB, "lock_enter");
    idle(LOCK, "lock_expire");

    // Wrong code then right code: fail count returns to zero; early relock with A
    enter_code(16'h5555, "wrong_then");
    idle(1, "wrong_then_idle");
    enter_code(16'h1234, "right_after");
    idle(3, "open2");
    press(4'h7, "open_ignored");
    press(4'hA, "early_relock");
    idle(2, "after_relock");

    // 5, A, C, D
    press(4'h5, "k5");
    press(4'hA, "kA");
    press(4'hC, "kC");
    press(4'hD, "kD");

    // Reset asserted mid-OPEN
    enter_code(16'h1234, "open3");
    idle(3, "open3_hold");
    async_reset("rst_mid_open");
    idle(2, "after_rst");

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: enter_code(PW, "rnd_pw");
        1: begin
          code = 16'($urandom);
          for (int k = 0; k < 4; k++) code[4*k +: 4] = 4'($urandom_range(0, 9));
          enter_code(code, "rnd_code");
        end
        2: for (int k = 0; k < 3; k++) tick(1'($urandom), 4'($urandom), "rnd_key");
        3: idle($urandom_range(1, 12), "rnd_idle");
        default: enter_code({4'h1, 4'h2, 4'h3, 4'($urandom_range(3, 5))}, "rnd_near");
      endcase
    end
    idle(LOCK + 2, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
